// File: rtl/pipe_reg_skid.sv
// pipe_reg_skid: valid/ready stage register with 2-entry skid buffer, flush and bubble-zeroed ctrl.
// Define PIPE_REG_SKID_STATS_EN to add the saturating stall_cnt output.
module pipe_reg_skid #(
    parameter int DATA_W = 69,
    parameter int CTRL_W = 2
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
`ifdef PIPE_REG_SKID_STATS_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);
    typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} state_t;
    state_t            r_state;
    logic [DATA_W-1:0] r_main_data, r_skid_data;
    logic [CTRL_W-1:0] r_main_ctrl, r_skid_ctrl;
    logic              w_accept, w_pop;
    assign in_ready  = r_state != FULL;
    assign out_valid = r_state != EMPTY;
    assign out_data  = r_main_data;
    assign out_ctrl  = out_valid ? r_main_ctrl : '0;
    assign occupancy = r_state == FULL ? 2'd2 : r_state == BUSY ? 2'd1 : 2'd0;
    assign w_accept  = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state     <= EMPTY;
            r_main_data <= '0;
            r_main_ctrl <= '0;
            r_skid_data <= '0;
            r_skid_ctrl <= '0;
        end else if (flush) begin
            r_state     <= EMPTY;
            r_main_ctrl <= '0;
            r_skid_ctrl <= '0;
        end else begin
            case (r_state)
                EMPTY: if (w_accept) begin
                    r_state     <= BUSY;
                    r_main_data <= in_data;
                    r_main_ctrl <= in_ctrl;
                end
                BUSY: if (w_accept && !w_pop) begin
                    r_state     <= FULL;
                    r_skid_data <= in_data;
                    r_skid_ctrl <= in_ctrl;
                end else if (w_accept) begin
                    r_main_data <= in_data;
                    r_main_ctrl <= in_ctrl;
                end else if (w_pop) begin
                    r_state <= EMPTY;
                end
                FULL: if (w_pop) begin
                    r_state     <= BUSY;
                    r_main_data <= r_skid_data;
                    r_main_ctrl <= r_skid_ctrl;
                end
                default: r_state <= EMPTY;
            endcase
        end
    end
`ifdef PIPE_REG_SKID_STATS_EN
    logic [15:0] r_stall_cnt;
    assign stall_cnt = r_stall_cnt;
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            r_stall_cnt <= '0;
        else if (out_valid && !out_ready && r_stall_cnt != 16'hFFFF)
            r_stall_cnt <= r_stall_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_pipe_reg_skid.sv
// tb_pipe_reg_skid: vector table, hand sequences and random traffic against a queue model.
module tb_pipe_reg_skid;
    localparam int DW = 69;
    localparam int CW = 2;
    logic          clock = 0, resetn = 0, in_valid = 0, flush = 0, out_ready = 0;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready, out_valid;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
`ifdef PIPE_REG_SKID_STATS_EN
    logic [15:0]   stall_cnt;
`endif
    int n_cmp = 0, n_bad = 0;

    pipe_reg_skid #(.DATA_W(DW), .CTRL_W(CW)) dut (
        .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .occupancy(occupancy)
`ifdef PIPE_REG_SKID_STATS_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;
    ent_t q[$];

    typedef struct {
        logic          iv;
        logic [CW-1:0] c;
        logic [DW-1:0] d;
        logic          fl;
        logic          ordy;
        logic          ev;
        logic [CW-1:0] ec;
        logic [DW-1:0] ed;
        logic [1:0]    eocc;
        logic          erdy;
    } vec_t;
    vec_t tbl[18];

    function automatic vec_t mk(logic iv, logic [1:0] c, int d, logic fl, logic ordy,
                                logic ev, logic [1:0] ec, int ed, int eocc, logic erdy);
        vec_t v;
        v.iv = iv; v.c = c; v.d = DW'(d); v.fl = fl; v.ordy = ordy;
        v.ev = ev; v.ec = ec; v.ed = DW'(ed); v.eocc = 2'(eocc); v.erdy = erdy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply inputs, clock once and advance the queue model by the stage's rules.
    task automatic step(input logic iv, input logic [CW-1:0] c, input logic [DW-1:0] d,
                        input logic fl, input logic ordy);
        logic acc, pop;
        ent_t e;
        in_valid = iv; in_ctrl = c; in_data = d; flush = fl; out_ready = ordy;
        acc = iv && q.size() < 2;
        pop = q.size() > 0 && ordy;
        @(posedge clock);
        if (fl) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (acc) begin e.c = c; e.d = d; q.push_back(e); end
        end
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".valid"}, 128'(out_valid), 128'(q.size() > 0));
        chk({tag, ".occ"}, 128'(occupancy), 128'(q.size()));
        chk({tag, ".ready"}, 128'(in_ready), 128'(q.size() < 2));
        chk({tag, ".ctrl"}, 128'(out_ctrl), q.size() > 0 ? 128'(q[0].c) : 128'(0));
        if (q.size() > 0) chk({tag, ".data"}, 128'(out_data), 128'(q[0].d));
    endtask

    initial begin
        logic [95:0] r;
        tbl[0]  = mk(1, 2'b01, 1,    0, 1, 1, 2'b01, 1,    1, 1);
        tbl[1]  = mk(1, 2'b01, 2,    0, 1, 1, 2'b01, 2,    1, 1);
        tbl[2]  = mk(1, 2'b01, 3,    0, 1, 1, 2'b01, 3,    1, 1);
        tbl[3]  = mk(0, 2'b00, 0,    0, 1, 0, 2'b00, 0,    0, 1);
        tbl[4]  = mk(1, 2'b10, 'h10, 0, 0, 1, 2'b10, 'h10, 1, 1);
        tbl[5]  = mk(1, 2'b10, 'h20, 0, 0, 1, 2'b10, 'h10, 2, 0);
        tbl[6]  = mk(1, 2'b11, 'h99, 0, 0, 1, 2'b10, 'h10, 2, 0);
        tbl[7]  = mk(0, 2'b00, 0,    0, 1, 1, 2'b10, 'h20, 1, 1);
        tbl[8]  = mk(0, 2'b00, 0,    0, 1, 0, 2'b00, 0,    0, 1);
        tbl[9]  = mk(1, 2'b01, 'h40, 0, 0, 1, 2'b01, 'h40, 1, 1);
        tbl[10] = mk(1, 2'b01, 'h41, 0, 0, 1, 2'b01, 'h40, 2, 0);
        tbl[11] = mk(1, 2'b01, 'h30, 1, 0, 0, 2'b00, 0,    0, 1);
        tbl[12] = mk(0, 2'b00, 0,    0, 1, 0, 2'b00, 0,    0, 1);
        tbl[13] = mk(1, 2'b11, 'h55, 0, 0, 1, 2'b11, 'h55, 1, 1);
        tbl[14] = mk(0, 2'b00, 0,    1, 0, 0, 2'b00, 0,    0, 1);
        tbl[15] = mk(0, 2'b00, 0,    0, 0, 0, 2'b00, 0,    0, 1);
        tbl[16] = mk(1, 2'b01, 'h66, 0, 0, 1, 2'b01, 'h66, 1, 1);
        tbl[17] = mk(1, 2'b01, 'h67, 1, 1, 0, 2'b00, 0,    0, 1);
        #12;
        chk("rst.valid", 128'(out_valid), 0);
        chk("rst.ready", 128'(in_ready), 1);
        chk("rst.occ", 128'(occupancy), 0);
        chk("rst.ctrl", 128'(out_ctrl), 0);
        chk("rst.data", 128'(out_data), 0);
        @(negedge clock) resetn = 1;
        @(posedge clock); #1;
        for (int i = 0; i < 18; i++) begin
            step(tbl[i].iv, tbl[i].c, tbl[i].d, tbl[i].fl, tbl[i].ordy);
            chk($sformatf("vec%0d.valid", i), 128'(out_valid), 128'(tbl[i].ev));
            chk($sformatf("vec%0d.ctrl", i), 128'(out_ctrl), 128'(tbl[i].ec));
            chk($sformatf("vec%0d.occ", i), 128'(occupancy), 128'(tbl[i].eocc));
            chk($sformatf("vec%0d.ready", i), 128'(in_ready), 128'(tbl[i].erdy));
            if (tbl[i].ev) chk($sformatf("vec%0d.data", i), 128'(out_data), 128'(tbl[i].ed));
        end
        // in_ready must not follow out_ready combinationally while FULL
        step(1, 2'b01, DW'('h70), 0, 0);
        step(1, 2'b01, DW'('h71), 0, 0);
        out_ready = 1; in_valid = 0; #1;
        chk("full.ready_no_comb", 128'(in_ready), 0);
        #1 resetn = 0; #1;
        q.delete();
        chk("async.valid", 128'(out_valid), 0);
        chk("async.ready", 128'(in_ready), 1);
        chk("async.occ", 128'(occupancy), 0);
        chk("async.ctrl", 128'(out_ctrl), 0);
        chk("async.data", 128'(out_data), 0);
        @(negedge clock) resetn = 1;
        @(posedge clock); #1;
        step(1, 2'b10, DW'('h77), 0, 1);
        chk_model("post_rst");
        for (int i = 0; i < 3000; i++) begin
            r = {32'($urandom), 32'($urandom), 32'($urandom)};
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            chk("rnd.ready_pre", 128'(in_ready), 128'(q.size() < 2));
            step(in_valid, CW'($urandom), r[DW-1:0], $urandom_range(0, 15) == 0, out_ready);
            chk_model("rnd");
        end
`ifdef PIPE_REG_SKID_STATS_EN
        resetn = 0; #1;
        q.delete();
        chk("stat.rst", 128'(stall_cnt), 0);
        @(negedge clock) resetn = 1;
        @(posedge clock); #1;
        step(1, 2'b01, DW'('h5), 0, 0);
        for (int i = 0; i < 5; i++) step(0, 2'b00, '0, 0, 0);
        chk("stat.five", 128'(stall_cnt), 5);
        step(0, 2'b00, '0, 1, 1);
        chk("stat.flush", 128'(stall_cnt), 5);
        step(1, 2'b01, DW'('h6), 0, 0);
        for (int i = 0; i < 65529; i++) step(0, 2'b00, '0, 0, 0);
        chk("stat.fffe", 128'(stall_cnt), 128'h0FFFE);
        for (int i = 0; i < 3; i++) step(0, 2'b00, '0, 0, 0);
        chk("stat.sat", 128'(stall_cnt), 128'h0FFFF);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
